// File: rtl/xt_kbd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : xt_kbd_receiver
// Purpose  : PC-side XT keyboard port receiver. Generates the free-running
//            keyboard clock, deserialises XT-format frames from the scan code
//            translator and presents each byte with a latched IRQ request.
// Ports    : CLK          system clock, rising edge
//            RESET        synchronous active-high reset
//            KBD_CLK      free-running keyboard clock (out)
//            KBD_DATA     serial XT data, changes just after KBD_CLK rises
//            KBD_RESET_N  keyboard reset, active low (out)
//            IRQ_CLEAR    one-cycle acknowledge strobe
//            SCAN_CODE    last delivered scan code (out, 8 bits)
//            IRQ          byte pending (out)
//            OVERRUN      sticky: byte arrived while IRQ set (out)
//            FRAME_ERR    one-cycle pulse on a discarded malformed frame (out)
// Revision : 1.0 - initial release
// ============================================================================
module xt_kbd_receiver #(
  parameter int HALF_PERIOD = 200
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       KBD_CLK,
  input  logic       KBD_DATA,
  output logic       KBD_RESET_N,
  input  logic       IRQ_CLEAR,
  output logic [7:0] SCAN_CODE,
  output logic       IRQ,
  output logic       OVERRUN,
  output logic       FRAME_ERR
);

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_START2 = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_fall_pipe;
  logic             r_strobe;
  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;

  logic w_fall_now;
  logic w_deliver;

  // KBD_CLK is about to go 1->0 on this edge.
  assign w_fall_now = (r_div == DIV_LAST) && KBD_CLK;
  assign w_deliver  = r_strobe && (r_state == ST_STOP) && r_sync2;

  // Keyboard clock generator and keyboard reset release.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div       <= '0;
      KBD_CLK     <= 1'b1;
      KBD_RESET_N <= 1'b0;
    end else begin
      KBD_RESET_N <= 1'b1;
      if (r_div == DIV_LAST) begin
        r_div   <= '0;
        KBD_CLK <= ~KBD_CLK;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // Data synchroniser and sample strobe. The fall event is delayed through
  // two flops then the strobe flop, so the strobe is high two cycles after
  // the cycle in which KBD_CLK became 0, in step with the synchronised data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_fall_pipe <= 2'b00;
      r_strobe    <= 1'b0;
    end else begin
      r_sync1     <= KBD_DATA;
      r_sync2     <= r_sync1;
      r_fall_pipe <= {r_fall_pipe[0], w_fall_now};
      r_strobe    <= r_fall_pipe[1];
    end
  end

  // Frame deserialiser.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      if (r_strobe) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_sync2) r_state <= ST_START2;
          end
          ST_START2: begin
            if (!r_sync2) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              r_state   <= ST_IDLE;
              FRAME_ERR <= 1'b1;
            end
          end
          ST_DATA: begin
            // LSB arrives first, so shifting right leaves D0 in bit 0.
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_STOP;
          end
          default: begin
            // Stop bit: a good stop is handled by w_deliver below.
            r_state <= ST_IDLE;
            if (!r_sync2) FRAME_ERR <= 1'b1;
          end
        endcase
      end
    end
  end

  // Host-side holding register. An acknowledge coinciding with a delivery
  // makes room for the new byte, so it loads rather than overruns.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SCAN_CODE <= 8'h00;
      IRQ       <= 1'b0;
      OVERRUN   <= 1'b0;
    end else if (w_deliver) begin
      if (!IRQ || IRQ_CLEAR) begin
        SCAN_CODE <= r_shift;
        IRQ       <= 1'b1;
        OVERRUN   <= 1'b0;
      end else begin
        OVERRUN <= 1'b1;
      end
    end else if (IRQ_CLEAR) begin
      IRQ     <= 1'b0;
      OVERRUN <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xt_kbd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_xt_kbd_receiver
// Purpose  : Self-checking bench for xt_kbd_receiver with HALF_PERIOD=4.
//            Table of frames with expected holding-register state, plus
//            hand-written sequences for framing errors and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xt_kbd_receiver;

  localparam int HP    = 4;
  localparam int BOUND = 64;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       KBD_CLK;
  logic       KBD_DATA;
  logic       KBD_RESET_N;
  logic       IRQ_CLEAR;
  logic [7:0] SCAN_CODE;
  logic       IRQ;
  logic       OVERRUN;
  logic       FRAME_ERR;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    bit         pre_clear;
    bit         clear_at_deliver;
    logic [7:0] exp_scan;
    bit         exp_irq;
    bit         exp_ovr;
  } vec_t;

  vec_t vecs[6];

  logic [7:0] cur_scan;
  logic       cur_irq;
  logic       cur_ovr;

  xt_kbd_receiver #(.HALF_PERIOD(HP)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .KBD_CLK     (KBD_CLK),
    .KBD_DATA    (KBD_DATA),
    .KBD_RESET_N (KBD_RESET_N),
    .IRQ_CLEAR   (IRQ_CLEAR),
    .SCAN_CODE   (SCAN_CODE),
    .IRQ         (IRQ),
    .OVERRUN     (OVERRUN),
    .FRAME_ERR   (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait until KBD_CLK makes a transition to lvl, observed 1 time unit after
  // the CLK edge that produced it.
  task automatic wait_kclk(input logic lvl);
    int k = 0;
    while (KBD_CLK === lvl && k < BOUND) begin tick(); k++; end
    while (KBD_CLK !== lvl && k < BOUND) begin tick(); k++; end
    if (k >= BOUND) begin
      checks++;
      errors++;
      $display("FAIL kbd_clk_timeout: KBD_CLK=%b never reached %b", KBD_CLK, lvl);
    end
  endtask

  // Drive bits[0..n-1], one per KBD_CLK period, changed just after the rise.
  // Returns right after the falling edge of the last bit (cycle T).
  task automatic send_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      wait_kclk(1'b1);
      KBD_DATA = bits[i];
      wait_kclk(1'b0);
    end
  endtask

  // Idle bit, two start bits, data LSB first, stop bit.
  function automatic logic [11:0] frame(input logic [7:0] d, input logic stop);
    return {stop, d, 2'b00, 1'b1};
  endfunction

  task automatic pulse_clear();
    IRQ_CLEAR = 1'b1;
    tick();
    IRQ_CLEAR = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_kbd_clk"}, {7'd0, KBD_CLK}, 8'd1);
    check({tag, "_kbd_reset_n"}, {7'd0, KBD_RESET_N}, 8'd0);
    check({tag, "_scan"}, SCAN_CODE, 8'h00);
    check({tag, "_irq"}, {7'd0, IRQ}, 8'd0);
    check({tag, "_ovr"}, {7'd0, OVERRUN}, 8'd0);
    check({tag, "_ferr"}, {7'd0, FRAME_ERR}, 8'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET     = 1'b1;
    KBD_DATA  = 1'b1;
    IRQ_CLEAR = 1'b0;

    //         data   pre  co   scan   irq  ovr
    vecs[0] = '{8'h1E, 1'b0, 1'b0, 8'h1E, 1'b1, 1'b0};
    vecs[1] = '{8'h1E, 1'b1, 1'b0, 8'h1E, 1'b1, 1'b0};
    vecs[2] = '{8'h9E, 1'b0, 1'b0, 8'h1E, 1'b1, 1'b1};
    vecs[3] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[4] = '{8'h2A, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};

    // Reset and keyboard clock start-up.
    repeat (3) tick();
    check_reset_values("reset");
    RESET = 1'b0;
    tick();
    check("rel_kbd_reset_n", {7'd0, KBD_RESET_N}, 8'd1);
    check("rel_kbd_clk_e1", {7'd0, KBD_CLK}, 8'd1);
    repeat (2) tick();
    check("rel_kbd_clk_e3", {7'd0, KBD_CLK}, 8'd1);
    tick();
    check("first_fall", {7'd0, KBD_CLK}, 8'd0);
    repeat (3) tick();
    check("low_hold", {7'd0, KBD_CLK}, 8'd0);
    tick();
    check("first_rise", {7'd0, KBD_CLK}, 8'd1);
    repeat (HP) tick();
    check("second_fall", {7'd0, KBD_CLK}, 8'd0);

    cur_scan = 8'h00;
    cur_irq  = 1'b0;
    cur_ovr  = 1'b0;

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pre_clear) begin
        pulse_clear();
        check($sformatf("v%0d_clr_irq", v), {7'd0, IRQ}, 8'd0);
        check($sformatf("v%0d_clr_ovr", v), {7'd0, OVERRUN}, 8'd0);
        check($sformatf("v%0d_clr_scan", v), SCAN_CODE, cur_scan);
        cur_irq = 1'b0;
        cur_ovr = 1'b0;
      end
      send_bits(frame(vecs[v].data, 1'b1), 12);
      repeat (2) tick();
      check($sformatf("v%0d_t2_scan", v), SCAN_CODE, cur_scan);
      check($sformatf("v%0d_t2_irq", v), {7'd0, IRQ}, {7'd0, cur_irq});
      check($sformatf("v%0d_t2_ovr", v), {7'd0, OVERRUN}, {7'd0, cur_ovr});
      if (vecs[v].clear_at_deliver) IRQ_CLEAR = 1'b1;
      tick();
      IRQ_CLEAR = 1'b0;
      check($sformatf("v%0d_scan", v), SCAN_CODE, vecs[v].exp_scan);
      check($sformatf("v%0d_irq", v), {7'd0, IRQ}, {7'd0, vecs[v].exp_irq});
      check($sformatf("v%0d_ovr", v), {7'd0, OVERRUN}, {7'd0, vecs[v].exp_ovr});
      check($sformatf("v%0d_ferr", v), {7'd0, FRAME_ERR}, 8'd0);
      cur_scan = vecs[v].exp_scan;
      cur_irq  = vecs[v].exp_irq;
      cur_ovr  = vecs[v].exp_ovr;
    end

    // Second start bit high: single FRAME_ERR pulse, holding state untouched.
    send_bits(12'b101, 3);
    repeat (2) tick();
    check("s2err_t2_ferr", {7'd0, FRAME_ERR}, 8'd0);
    tick();
    check("s2err_t3_ferr", {7'd0, FRAME_ERR}, 8'd1);
    check("s2err_scan", SCAN_CODE, cur_scan);
    check("s2err_irq", {7'd0, IRQ}, {7'd0, cur_irq});
    tick();
    check("s2err_t4_ferr", {7'd0, FRAME_ERR}, 8'd0);

    // Stop bit low: FRAME_ERR pulse, no delivery.
    pulse_clear();
    send_bits(frame(8'h33, 1'b0), 12);
    repeat (3) tick();
    check("stoperr_ferr", {7'd0, FRAME_ERR}, 8'd1);
    check("stoperr_scan", SCAN_CODE, cur_scan);
    check("stoperr_irq", {7'd0, IRQ}, 8'd0);
    check("stoperr_ovr", {7'd0, OVERRUN}, 8'd0);
    tick();
    check("stoperr_ferr_end", {7'd0, FRAME_ERR}, 8'd0);

    // Reset after the 4th data bit, then a clean frame.
    send_bits({5'b00000, 4'b1010, 2'b00, 1'b1}, 7);
    tick();
    RESET = 1'b1;
    tick();
    check_reset_values("midrst");
    tick();
    RESET    = 1'b0;
    KBD_DATA = 1'b1;
    send_bits(frame(8'h10, 1'b1), 12);
    repeat (2) tick();
    check("post_t2_irq", {7'd0, IRQ}, 8'd0);
    tick();
    check("post_scan", SCAN_CODE, 8'h10);
    check("post_irq", {7'd0, IRQ}, 8'd1);
    check("post_ovr", {7'd0, OVERRUN}, 8'd0);
    check("post_ferr", {7'd0, FRAME_ERR}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xt_kbd_receiver.md
# xt_kbd_receiver

PC-side XT keyboard port receiver. It sits directly downstream of the PS/2-to-XT scan code translator. It generates the free-running keyboard clock that drives the translator and the PS/2 keyboard. It deserialises the translator's XT-format serial output into bytes and presents each byte to the CPU side with an interrupt request, which stays pending until explicitly cleared.

## Interface
Parameters:
- HALF_PERIOD, 200, CLK cycles per KBD_CLK half-period; legal range 4..65535 (200 at 4.77 MHz gives about 11.9 kHz).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- KBD_CLK  out  1  keyboard clock to translator, free-running square wave.
- KBD_DATA  in  1  serial XT data from translator; changes just after KBD_CLK rises.
- KBD_RESET_N  out  1  keyboard reset to translator, active low.
- IRQ_CLEAR  in  1  one-cycle strobe that acknowledges the current byte (PB7 equivalent).
- SCAN_CODE  out  8  last delivered XT scan code.
- IRQ  out  1  byte pending (IRQ1 request).
- OVERRUN  out  1  sticky flag: a byte arrived while IRQ was already set.
- FRAME_ERR  out  1  one-cycle pulse: malformed frame discarded.

## Operation
- **Reset values:** KBD_CLK=1, divider=0, KBD_RESET_N=0, SCAN_CODE=0x00, IRQ=0, OVERRUN=0, FRAME_ERR=0, FSM=IDLE, shift register=0, both synchroniser flops=1.
- **KBD_RESET_N:** registered. It goes 1 on the first cycle after RESET deasserts.
- **Clock generator:**
  - Divider counts 0..HALF_PERIOD-1.
  - At terminal count, KBD_CLK toggles and the divider wraps to 0.
  - KBD_CLK never stops outside reset.
- **Synchroniser:** KBD_DATA passes through 2 flops before the FSM uses it.
- **Sample strobe:** asserts exactly 2 cycles after each cycle in which KBD_CLK goes 1->0, and samples the synchronised data.
- **Frame format:** data stays idle high. Each frame is, per KBD_CLK period:
  - 0 (start 1)
  - 0 (start 2)
  - D0..D7, LSB first
  - 1 (stop)
- **FSM transitions (only on sample strobe):**
  - IDLE: sample 0 -> START2; sample 1 -> IDLE.
  - START2: sample 0 -> DATA with bit count 0; sample 1 -> IDLE with FRAME_ERR pulse.
  - DATA: shift the sample into bit 7 (shift right) and increment the count. After the 8th bit -> STOP.
  - STOP: sample 1 -> deliver, then IDLE. Sample 0 -> FRAME_ERR pulse, then IDLE, byte discarded.
- **Deliver with IRQ=0:** SCAN_CODE <= shift register; IRQ <= 1.
- **Deliver with IRQ=1:** SCAN_CODE is unchanged; OVERRUN <= 1; the new byte is dropped.
- **IRQ_CLEAR alone:** IRQ <= 0 and OVERRUN <= 0. SCAN_CODE holds its value.
- **Deliver and IRQ_CLEAR in the same cycle:** the new byte loads into SCAN_CODE, IRQ stays 1, OVERRUN <= 0.
- **Bit 7:** passed through unmodified; a set bit 7 marks a break code.
- **Silent break prefix:** the translator sends no frame for a 0xF0 prefix. The receiver simply stays in IDLE.
- **Reset mid-frame:** all state returns to reset values immediately. The partial byte is lost and no FRAME_ERR is raised.

## Timing
- **KBD_CLK period:** 2*HALF_PERIOD cycles.
- **First edge after reset:** the first falling edge occurs HALF_PERIOD cycles after RESET deasserts.
- **Sample point:** KBD_DATA changes after a rising edge. It is captured at the following falling edge, which is HALF_PERIOD cycles later; with 2-cycle synchronisation this leaves margin for HALF_PERIOD >= 4.
- **Delivery latency:** if the falling edge of the stop bit is at cycle T, SCAN_CODE, IRQ and OVERRUN update at T+3.
- **FRAME_ERR:** high for exactly cycle T+3 of the offending sample.
- **Frame length:** one frame is 11 KBD_CLK periods.
- **Single-edge use:** a stop bit cannot also serve as the next start bit. The next frame starts at the earliest on the following falling edge.

## Test plan
- HALF_PERIOD=4; reset for 3 cycles, then release.
  - Expect KBD_CLK=1 and KBD_RESET_N=0 during reset.
  - KBD_RESET_N=1 on the first cycle after release.
  - KBD_CLK falls 4 cycles after release, then toggles every 4 cycles.
- Drive frame 0,0,0x1E LSB-first,1 aligned to rising edges.
  - SCAN_CODE=0x1E, IRQ=1 at stop-fall+3.
  - IRQ_CLEAR pulse -> IRQ=0, SCAN_CODE stays 0x1E.
- Send 0x9E without clearing, after a pending 0x1E.
  - SCAN_CODE stays 0x1E, OVERRUN=1.
  - IRQ_CLEAR -> OVERRUN=0, IRQ=0.
- Send 0x2A timed so IRQ_CLEAR coincides with the delivery cycle.
  - SCAN_CODE=0x2A, IRQ=1, OVERRUN=0.
- Framing errors:
  - Frame with second start bit = 1 -> FRAME_ERR single pulse; SCAN_CODE/IRQ unchanged.
  - Frame with stop = 0 -> FRAME_ERR pulse; no delivery.
- Assert RESET after the 4th data bit of a frame.
  - All outputs return to reset values.
  - A following clean 0x10 frame delivers 0x10 correctly.
